display_window_ctrl: RTL
========================

DISPLAY_WINDOW_CTRL -- requirements
Module: display_window_ctrl

Interface
- REQ-001 SHALL have parameter PPC, default 2, pixels per clock (1, 2 or 4).
- REQ-002 SHALL have parameter P_DEPTH, default 8, bits per colour component.
- REQ-003 SHALL have parameters H_SYNC/H_BP/H_ACT/H_FP, defaults 100/100/1080/200, in pixels; each divisible by PPC.
- REQ-004 SHALL have parameters V_SYNC/V_BP/V_ACT/V_FP, defaults 3/5/1920/6, in lines.
- REQ-005 SHALL have parameters WIN_X/WIN_Y/WIN_W/WIN_H, defaults 0/420/1080/1080, image window inside the active area, in pixels/lines; WIN_X and WIN_W divisible by PPC.
- REQ-006 SHALL have parameter FIFO_DEPTH, default 1024, power of two, in beats.
- REQ-007 clk  in  1  single clock.
- REQ-008 rst_n  in  1  asynchronous active-low reset.
- REQ-009 timing_en  in  1  timing generator run enable; low holds counters at zero.
- REQ-010 s_data  in  PPC*3*P_DEPTH  pixel beat, per-pixel order {B,G,R}, pixel 0 in the LSBs.
- REQ-011 s_valid  in  1 / s_ready  out  1  input handshake.
- REQ-012 bg_color  in  3*P_DEPTH  fill colour used outside the window.
- REQ-013 blank_tog  in  1  each rising edge toggles blanking.
- REQ-014 o_hs, o_vs, o_de  out  1 each  active-high timing.
- REQ-015 o_data  out  PPC*3*P_DEPTH  output pixels.
- REQ-016 frame_cnt  out  16  completed-frame count.
- REQ-017 ovf_sticky, unf_sticky  out  1 each  FIFO error flags.
- REQ-018 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
- REQ-019 The horizontal counter SHALL count beats 0..(H_SYNC+H_BP+H_ACT+H_FP)/PPC-1 and wrap; the vertical counter SHALL advance on horizontal wrap and wrap after V_SYNC+V_BP+V_ACT+V_FP lines.
- REQ-020 Sync SHALL be asserted while the counter is below the sync width; DE SHALL be asserted within [SYNC+BP, SYNC+BP+ACT) on both axes.
- REQ-021 o_hs/o_vs/o_de SHALL lag the internal counters by exactly 2 clocks, aligned to o_data.
- REQ-022 A FIFO write SHALL occur when s_valid && s_ready; s_ready SHALL be high when fifo_level < FIFO_DEPTH-4.
- REQ-023 A write attempt while full SHALL be dropped and SHALL set ovf_sticky.
- REQ-024 "armed" SHALL be set on a falling edge of internal VS when fifo_level >= FIFO_DEPTH/2, and SHALL clear only when timing_en is low or on reset.
- REQ-025 A FIFO read SHALL occur on each DE beat inside the window while armed.
- REQ-026 A read request while empty SHALL set unf_sticky, SHALL pop nothing, and SHALL output bg for that beat.
- REQ-027 The output pixel SHALL be FIFO data for window beats, otherwise the latched bg colour replicated PPC times; all zero while blanked or outside DE.
- REQ-028 bg_color SHALL be latched only on a falling edge of internal VS; no mid-frame change.
- REQ-029 frame_cnt SHALL increment, wrapping at 16 bits, on the last active beat of the last active line.
- REQ-030 A simultaneous read and write SHALL leave fifo_level unchanged.
- REQ-031 Deasserting timing_en mid-frame SHALL zero the counters and force o_hs/o_vs/o_de low within 2 clocks; FIFO contents SHALL be preserved.

Reset
- REQ-032 On rst_n low, all outputs SHALL be 0, except s_ready=1; the FIFO SHALL be emptied; armed, blank, latched bg and sticky flags SHALL be cleared.
- REQ-033 Reset deassertion SHALL take effect on the next clk edge; no output glitch SHALL occur during reset.

Configuration
- REQ-034 With DISPLAY_TEST_PATTERN_EN defined, an extra input tp_sel (1 bit) SHALL exist; tp_sel=1 SHALL replace window pixels with 8 equal-width vertical colour bars (white, yellow, cyan, green, magenta, red, blue, black) and SHALL stop FIFO reads.
- REQ-035 Without DISPLAY_TEST_PATTERN_EN, tp_sel SHALL be absent and behaviour SHALL be per REQ-027.

Verification (PPC=2, P_DEPTH=8, H 2/2/8/2, V 1/1/4/1, WIN 2/1/4/2, FIFO_DEPTH=16)
- REQ-036 Reset, then timing_en=1 -> o_hs high 1 beat per 7-beat line; o_vs high 1 line per 7-line frame; o_de 4 beats × 4 lines.
- REQ-037 Preload 8 beats, bg=0x0000FF -> window beats carry FIFO data in order; other DE beats show 0x0000FF; frame_cnt=1 after frame 1.
- REQ-038 Preload 7 beats at VS fall -> armed stays 0 and all DE beats show bg.
- REQ-039 Arm with 8 beats, no further writes -> unf_sticky=1 on the first empty window read; that beat shows bg.
- REQ-040 Write 17 beats while ignoring s_ready -> ovf_sticky=1; fifo_level=16; s_ready=0 from level 12.
- REQ-041 Pulse blank_tog mid-frame -> o_data=0 from the next beat while timing continues; a second pulse restores the image.

Source files
------------

// File: rtl/display_window_ctrl.sv
// Raster timing generator that shows a FIFO-fed image window over a latched background colour.
// Define DISPLAY_TEST_PATTERN_EN to add tp_sel, which swaps window pixels for 8 vertical colour bars.
module display_window_ctrl #(
    parameter int unsigned PPC        = 2,
    parameter int unsigned P_DEPTH    = 8,
    parameter int unsigned H_SYNC     = 100,
    parameter int unsigned H_BP       = 100,
    parameter int unsigned H_ACT      = 1080,
    parameter int unsigned H_FP       = 200,
    parameter int unsigned V_SYNC     = 3,
    parameter int unsigned V_BP       = 5,
    parameter int unsigned V_ACT      = 1920,
    parameter int unsigned V_FP       = 6,
    parameter int unsigned WIN_X      = 0,
    parameter int unsigned WIN_Y      = 420,
    parameter int unsigned WIN_W      = 1080,
    parameter int unsigned WIN_H      = 1080,
    parameter int unsigned FIFO_DEPTH = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          timing_en,
    input  logic [PPC*3*P_DEPTH-1:0]      s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [3*P_DEPTH-1:0]          bg_color,
    input  logic                          blank_tog,
`ifdef DISPLAY_TEST_PATTERN_EN
    input  logic                          tp_sel,
`endif
    output logic                          o_hs,
    output logic                          o_vs,
    output logic                          o_de,
    output logic [PPC*3*P_DEPTH-1:0]      o_data,
    output logic [15:0]                   frame_cnt,
    output logic                          ovf_sticky,
    output logic                          unf_sticky,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int unsigned PW    = 3 * P_DEPTH;
    localparam int unsigned DW    = PPC * PW;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned H_TOT = (H_SYNC + H_BP + H_ACT + H_FP) / PPC;
    localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int unsigned HW    = $clog2(H_TOT + 1);
    localparam int unsigned VW    = $clog2(V_TOT + 1);

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_SYNCE = HW'(H_SYNC / PPC);
    localparam logic [HW-1:0] H_ACTS  = HW'((H_SYNC + H_BP) / PPC);
    localparam logic [HW-1:0] H_ACTE  = HW'((H_SYNC + H_BP + H_ACT) / PPC);
    localparam logic [HW-1:0] H_ACTL  = HW'((H_SYNC + H_BP + H_ACT) / PPC - 1);
    localparam logic [HW-1:0] H_WINS  = HW'((H_SYNC + H_BP + WIN_X) / PPC);
    localparam logic [HW-1:0] H_WINE  = HW'((H_SYNC + H_BP + WIN_X + WIN_W) / PPC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_SYNCE = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACTS  = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACTE  = VW'(V_SYNC + V_BP + V_ACT);
    localparam logic [VW-1:0] V_ACTL  = VW'(V_SYNC + V_BP + V_ACT - 1);
    localparam logic [VW-1:0] V_WINS  = VW'(V_SYNC + V_BP + WIN_Y);
    localparam logic [VW-1:0] V_WINE  = VW'(V_SYNC + V_BP + WIN_Y + WIN_H);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          hs_c, vs_c, de_c, win_c, vs_fall, last_beat;
    logic          vs_prev_q, armed_q, blank_q, blank_tog_q;
    logic [PW-1:0] bg_q;
    logic [15:0]   frame_cnt_q;
    logic          ovf_q, unf_q;

    logic [DW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          empty, full, wr_en, rd_req, rd_en, tp_on;

    logic          hs1_q, vs1_q, de1_q, pop1_q, tp1_q;
    logic [DW-1:0] rdat1_q, tp_pix1_q, pix_d;
    logic          hs2_q, vs2_q, de2_q;
    logic [DW-1:0] pix2_q;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!timing_en) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end else begin
            h_d = h_q + HW'(1);
        end
    end

    // Timing decode is gated by timing_en so a disable forces the outputs low within the pipeline delay
    assign hs_c      = timing_en && (h_q < H_SYNCE);
    assign vs_c      = timing_en && (v_q < V_SYNCE);
    assign de_c      = timing_en && (h_q >= H_ACTS) && (h_q < H_ACTE) && (v_q >= V_ACTS) && (v_q < V_ACTE);
    assign win_c     = de_c && (h_q >= H_WINS) && (h_q < H_WINE) && (v_q >= V_WINS) && (v_q < V_WINE);
    assign vs_fall   = timing_en && vs_prev_q && !vs_c;
    assign last_beat = de_c && (h_q == H_ACTL) && (v_q == V_ACTL);

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(FIFO_DEPTH));
    assign s_ready = (level_q < LW'(FIFO_DEPTH - 4));
    assign wr_en   = s_valid && !full;
    assign rd_req  = win_c && armed_q && !tp_on;
    assign rd_en   = rd_req && !empty;

    always_comb begin
        level_d = level_q;
        if (wr_en && !rd_en) begin
            level_d = level_q + LW'(1);
        end else if (rd_en && !wr_en) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= s_data;
        end
        rdat1_q <= mem[rd_ptr_q];
    end

`ifdef DISPLAY_TEST_PATTERN_EN
    logic [DW-1:0] tp_pix_d;
    logic [31:0]   xo, bar;

    assign tp_on = tp_sel;

    // Bar index per pixel: RGB bits of white..black are R=~bar[1], G=~bar[2], B=~bar[0]
    always_comb begin
        tp_pix_d = '0;
        xo       = '0;
        bar      = '0;
        for (int unsigned p = 0; p < PPC; p++) begin
            xo  = (32'(h_q) - 32'(H_WINS)) * PPC + p;
            bar = (xo * 8) / WIN_W;
            tp_pix_d[p*PW +: PW] = {{P_DEPTH{~bar[0]}}, {P_DEPTH{~bar[2]}}, {P_DEPTH{~bar[1]}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp1_q     <= 1'b0;
            tp_pix1_q <= '0;
        end else begin
            tp1_q     <= win_c && tp_sel;
            tp_pix1_q <= tp_pix_d;
        end
    end
`else
    assign tp_on     = 1'b0;
    assign tp1_q     = 1'b0;
    assign tp_pix1_q = '0;
`endif

    always_comb begin
        pix_d = '0;
        if (de1_q && !blank_q) begin
            if (pop1_q) begin
                pix_d = rdat1_q;
            end else if (tp1_q) begin
                pix_d = tp_pix1_q;
            end else begin
                pix_d = {PPC{bg_q}};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q         <= '0;
            v_q         <= '0;
            vs_prev_q   <= 1'b0;
            armed_q     <= 1'b0;
            blank_q     <= 1'b0;
            blank_tog_q <= 1'b0;
            bg_q        <= '0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            hs1_q       <= 1'b0;
            vs1_q       <= 1'b0;
            de1_q       <= 1'b0;
            pop1_q      <= 1'b0;
            hs2_q       <= 1'b0;
            vs2_q       <= 1'b0;
            de2_q       <= 1'b0;
            pix2_q      <= '0;
        end else begin
            h_q         <= h_d;
            v_q         <= v_d;
            vs_prev_q   <= vs_c;
            blank_tog_q <= blank_tog;
            if (blank_tog && !blank_tog_q) begin
                blank_q <= !blank_q;
            end
            if (!timing_en) begin
                armed_q <= 1'b0;
            end else if (vs_fall && (level_q >= LW'(FIFO_DEPTH / 2))) begin
                armed_q <= 1'b1;
            end
            if (vs_fall) begin
                bg_q <= bg_color;
            end
            if (last_beat) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (s_valid && full) begin
                ovf_q <= 1'b1;
            end
            if (rd_req && empty) begin
                unf_q <= 1'b1;
            end
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
            hs1_q   <= hs_c;
            vs1_q   <= vs_c;
            de1_q   <= de_c;
            pop1_q  <= rd_en;
            hs2_q   <= hs1_q;
            vs2_q   <= vs1_q;
            de2_q   <= de1_q;
            pix2_q  <= pix_d;
        end
    end

    assign o_hs       = hs2_q;
    assign o_vs       = vs2_q;
    assign o_de       = de2_q;
    assign o_data     = pix2_q;
    assign frame_cnt  = frame_cnt_q;
    assign ovf_sticky = ovf_q;
    assign unf_sticky = unf_q;
    assign fifo_level = level_q;

endmodule
